adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base of a 16-byte register window.
REQ-002 SHALL have wb_clk_i  input  1  sole clock.
REQ-003 SHALL have wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone strobe, cycle, write-enable.
REQ-005 SHALL have wbs_sel_i  input  4  byte enables; wbs_adr_i, wbs_dat_i  input  32 each  address, write data.
REQ-006 SHALL have wbs_ack_o  output  1  acknowledge; wbs_dat_o  output  32  read data.
REQ-007 SHALL have add_a, add_b  output  8 each  operands to the external registered 8-bit adder.
REQ-008 SHALL have add_sum  input  8 and add_cout  input  1  adder result, valid one clock after add_a/add_b change.
REQ-009 SHALL have irq  output  1  completion interrupt.

Function
REQ-010 Register map (offset from BASE_ADDR): 0x0 OPND [7:0]=A, [15:8]=B RW; 0x4 CTRL [0]=START (write-1, reads 0), [1]=IRQ_EN, [15:8]=COUNT, RW; 0x8 STATUS [0]=BUSY RO, [1]=DONE W1C, [2]=ERR W1C; 0xC RESULT [15:0] RO.
REQ-011 Writes SHALL honour wbs_sel_i per byte; unmapped bits read 0.
REQ-012 Access with stb&cyc&!ack and wbs_adr_i in [BASE_ADDR, BASE_ADDR+0xF], word-aligned: wbs_ack_o high exactly one cycle, registered; never on consecutive cycles.
REQ-013 Addresses outside the window SHALL never be acknowledged; wbs_dat_o SHALL be 0 when ack is low.
REQ-014 FSM states: IDLE, LOAD, EXEC, CAPT, DONE.
REQ-015 IDLE: START=1 write with COUNT>0 -> clear DONE, acc<=zero-extended A, iter<=COUNT, go LOAD.
REQ-016 START with COUNT=0 -> RESULT<=zero-extended A, DONE set next edge, no adder issue, stay IDLE.
REQ-017 LOAD: register add_a<=acc[7:0], add_b<=B; go EXEC.
REQ-018 EXEC: wait one cycle for adder; go CAPT.
REQ-019 CAPT: acc[7:0]<=add_sum, acc[15:8]<=acc[15:8]+add_cout (mod 256), iter<=iter-1; iter was 1 -> DONE, else LOAD.
REQ-020 DONE: RESULT<=acc, DONE bit set, BUSY cleared; go IDLE (one cycle).
REQ-021 Per-job latency: 3*COUNT+1 cycles from START-ack edge to DONE bit set; BUSY=1 exactly in LOAD/EXEC/CAPT/DONE.
REQ-022 Result SHALL equal A + COUNT*B exactly (max 0xFF00, no overflow possible).
REQ-023 Writes to OPND or CTRL while BUSY SHALL be acknowledged but ignored; START while BUSY SHALL set ERR.
REQ-024 DONE W1C in same cycle as DONE set: set wins.
REQ-025 RESULT SHALL hold until next job completes; add_a/add_b hold last value outside LOAD.
REQ-026 irq SHALL equal DONE & IRQ_EN, registered.

Reset
REQ-027 wb_rst_i assertion SHALL immediately force IDLE and zero wbs_ack_o, wbs_dat_o, add_a, add_b, irq, A, B, COUNT, IRQ_EN, acc, iter, RESULT, DONE, ERR, BUSY.
REQ-028 Reset mid-job SHALL abort without setting DONE; first job after release runs normally.

Verification
REQ-029 Reset, read all four registers -> all 0x0000_0000, irq=0.
REQ-030 A=0x10, B=0x20, COUNT=1, IRQ_EN=1, START -> BUSY for 4 cycles, RESULT=0x0030, DONE=1, irq=1; write 0x2 to STATUS -> DONE=0, irq=0.
REQ-031 A=0xFF, B=0x01, COUNT=1 -> RESULT=0x0100 (carry into high byte).
REQ-032 A=0xFF, B=0xFF, COUNT=255 -> RESULT=0xFF00 after 766 cycles.
REQ-033 COUNT=0, A=0x5A, START -> RESULT=0x005A, DONE next cycle, add_a unchanged.
REQ-034 COUNT=10 job; START write mid-job -> ERR=1, job unaffected (RESULT=A+10*B); separate run: wb_rst_i pulse mid-job -> all registers 0, DONE=0.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - Wishbone-controlled sequencer computing A + COUNT*B on an external registered adder
//
// Ports:
//   wb_clk_i, wb_rst_i          clock; asynchronous active-high reset
//   wbs_stb_i/cyc_i/we_i/sel_i  Wishbone slave request, byte enables
//   wbs_adr_i, wbs_dat_i        request address and write data
//   wbs_ack_o, wbs_dat_o        registered one-cycle acknowledge, read data (0 when not acking)
//   add_a, add_b                operands driven to the external 8-bit adder
//   add_sum, add_cout           adder result, valid one clock after the operands change
//   irq                         registered DONE & IRQ_EN
//
// Register window (offset from BASE_ADDR):
//   0x0 OPND   [7:0]=A [15:8]=B
//   0x4 CTRL   [0]=START (reads 0) [1]=IRQ_EN [15:8]=COUNT
//   0x8 STATUS [0]=BUSY [1]=DONE (W1C) [2]=ERR (W1C)
//   0xC RESULT [15:0]
module adder_seq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    input  logic [7:0]  add_sum,
    input  logic        add_cout,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_CAPT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  opnd_a;
    logic [7:0]  opnd_b;
    logic [7:0]  count;
    logic        irq_en;
    logic        done;
    logic        err;
    logic [15:0] acc;
    logic [7:0]  iter;
    logic [15:0] result;

    logic [31:0] offset;
    logic        in_win;
    logic        hit;
    logic        wr;
    logic [1:0]  reg_idx;
    logic        busy;
    logic        start_req;
    logic [7:0]  count_eff;
    logic        go;
    logic        zero_job;
    logic        done_w1c;
    logic        err_w1c;
    logic [31:0] rdata;

    // Window decode as a range check so a non 16-byte-aligned base still works.
    assign offset   = wbs_adr_i - BASE_ADDR;
    assign in_win   = (wbs_adr_i >= BASE_ADDR) && (offset[31:4] == 28'd0);
    // Gating on !ack keeps the acknowledge from ever repeating on back-to-back cycles.
    assign hit      = wbs_stb_i && wbs_cyc_i && !wbs_ack_o && in_win && (wbs_adr_i[1:0] == 2'b00);
    assign wr       = hit && wbs_we_i;
    assign reg_idx  = offset[3:2];
    assign busy     = (state != S_IDLE);

    assign start_req = wr && (reg_idx == 2'd1) && wbs_sel_i[0] && wbs_dat_i[0];
    // A START write may carry its own COUNT in the same access; that value governs the job.
    assign count_eff = wbs_sel_i[1] ? wbs_dat_i[15:8] : count;
    assign go        = start_req && !busy && (count_eff != 8'd0);
    assign zero_job  = start_req && !busy && (count_eff == 8'd0);
    assign done_w1c  = wr && (reg_idx == 2'd2) && wbs_sel_i[0] && wbs_dat_i[1];
    assign err_w1c   = wr && (reg_idx == 2'd2) && wbs_sel_i[0] && wbs_dat_i[2];

    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            2'd0: rdata = {16'd0, opnd_b, opnd_a};
            2'd1: rdata = {16'd0, count, 6'd0, irq_en, 1'b0};
            2'd2: rdata = {29'd0, err, done, busy};
            2'd3: rdata = {16'd0, result};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (go) state_next = S_LOAD;
            S_LOAD: state_next = S_EXEC;
            S_EXEC: state_next = S_CAPT;
            S_CAPT: state_next = (iter == 8'd1) ? S_DONE : S_LOAD;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            add_a     <= 8'd0;
            add_b     <= 8'd0;
            irq       <= 1'b0;
            opnd_a    <= 8'd0;
            opnd_b    <= 8'd0;
            count     <= 8'd0;
            irq_en    <= 1'b0;
            acc       <= 16'd0;
            iter      <= 8'd0;
            result    <= 16'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= (hit && !wbs_we_i) ? rdata : 32'd0;

            // Operand and control writes are acknowledged but dropped while a job runs.
            if (wr && !busy && (reg_idx == 2'd0)) begin
                if (wbs_sel_i[0]) opnd_a <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) opnd_b <= wbs_dat_i[15:8];
            end
            if (wr && !busy && (reg_idx == 2'd1)) begin
                if (wbs_sel_i[0]) irq_en <= wbs_dat_i[1];
                if (wbs_sel_i[1]) count  <= wbs_dat_i[15:8];
            end

            // Setting beats a same-cycle W1C clear.
            if ((state == S_DONE) || zero_job) begin
                done <= 1'b1;
            end else if (done_w1c || go) begin
                done <= 1'b0;
            end

            if (start_req && busy) begin
                err <= 1'b1;
            end else if (err_w1c) begin
                err <= 1'b0;
            end

            if (go) begin
                acc  <= {8'd0, opnd_a};
                iter <= count_eff;
            end
            if (zero_job) begin
                result <= {8'd0, opnd_a};
            end

            case (state)
                S_LOAD: begin
                    add_a <= acc[7:0];
                    add_b <= opnd_b;
                end
                S_CAPT: begin
                    acc  <= {acc[15:8] + {7'd0, add_cout}, add_sum};
                    iter <= iter - 8'd1;
                end
                S_DONE: result <= acc;
                default: ;
            endcase

            irq <= done && irq_en;
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - randomized self-checking bench for adder_seq_ctrl
module tb_adder_seq_ctrl;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] OPND   = BASE + 32'h0;
    localparam logic [31:0] CTRL   = BASE + 32'h4;
    localparam logic [31:0] STATUS = BASE + 32'h8;
    localparam logic [31:0] RESULT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] adr = 32'd0;
    logic [31:0] wdat = 32'd0;
    logic        ack;
    logic [31:0] rdat_o;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_sum = 8'd0;
    logic        add_cout = 1'b0;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Expected adder operands left behind by the last job that used the adder.
    logic [7:0] exp_add_a = 8'd0;
    logic [7:0] exp_add_b = 8'd0;

    always #5 clk = ~clk;

    // External registered adder.
    always @(posedge clk) begin
        {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b};
    end

    adder_seq_ctrl #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat_o),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        logic got;
        got = 1'b0;
        r   = 32'd0;
        @(posedge clk); #1;
        adr = a; we = w; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                r   = rdat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(a, 1'b1, d, s, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(a, 1'b0, 32'd0, 4'hF, r);
        chk(tag, r, exp);
    endtask

    task automatic wait_irq(input int limit, output int n);
        n = 0;
        while (!irq && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("irq_within_bound", {31'd0, irq}, 32'd1);
    endtask

    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int n;
        int exp_res;
        exp_res = int'(a) + int'(c) * int'(b);
        wb_wr(OPND, {16'd0, b, a}, 4'b0011);
        wb_wr(CTRL, {16'd0, c, 8'h03}, 4'b0011);
        wait_irq(3000, n);
        // irq is one registered cycle behind DONE, which lands 3*COUNT+1 cycles after START.
        chk("latency", n, 3 * int'(c) + 2);
        rd_chk("result", RESULT, exp_res);
        rd_chk("status_done", STATUS, 32'h2);
        exp_add_a = 8'((int'(a) + (int'(c) - 1) * int'(b)) & 8'hFF);
        exp_add_b = b;
        chk("add_a_hold", {24'd0, add_a}, {24'd0, exp_add_a});
        chk("add_b_hold", {24'd0, add_b}, {24'd0, exp_add_b});
        wb_wr(STATUS, 32'h2, 4'b0001);
        rd_chk("status_clr", STATUS, 32'h0);
        chk("irq_clr", {31'd0, irq}, 32'd0);
    endtask

    task automatic probe_no_ack(input string tag, input logic [31:0] a);
        int acks;
        logic [31:0] dat_or;
        acks = 0;
        dat_or = 32'd0;
        @(posedge clk); #1;
        adr = a; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (ack) acks++;
            dat_or = dat_or | rdat_o;
        end
        stb = 1'b0; cyc = 1'b0;
        chk(tag, acks, 0);
        chk({tag, "_dat"}, dat_or, 32'd0);
    endtask

    initial begin
        int n;
        int acks;
        logic [7:0] ra, rb, rc;

        #23 rst = 1'b0;

        // Reset state.
        rd_chk("rst_opnd", OPND, 32'h0);
        rd_chk("rst_ctrl", CTRL, 32'h0);
        rd_chk("rst_status", STATUS, 32'h0);
        rd_chk("rst_result", RESULT, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // Byte enables and unmapped bits.
        wb_wr(OPND, 32'hFFFF_FFFF, 4'hF);
        rd_chk("opnd_unmapped", OPND, 32'h0000_FFFF);
        wb_wr(OPND, 32'h0000_AB12, 4'b0001);
        rd_chk("opnd_sel0", OPND, 32'h0000_FF12);
        wb_wr(CTRL, 32'hFFFF_FFFE, 4'hF);
        rd_chk("ctrl_unmapped", CTRL, 32'h0000_FF02);
        wb_wr(CTRL, 32'h0, 4'hF);

        // Address decode.
        probe_no_ack("oow_high", BASE + 32'h10);
        probe_no_ack("oow_low", BASE - 32'h4);
        probe_no_ack("misaligned", BASE + 32'h1);

        // Acknowledge never repeats while the strobe stays up.
        @(posedge clk); #1;
        adr = OPND; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        acks = 0;
        for (int k = 0; k < 10 && !ack; k++) begin
            @(posedge clk); #1;
        end
        if (ack) acks++;
        @(posedge clk); #1;
        chk("ack_single", {31'd0, ack}, 32'd0);
        chk("ack_single_dat", rdat_o, 32'd0);
        stb = 1'b0; cyc = 1'b0;
        chk("ack_first", acks, 1);

        // Directed jobs.
        run_job(8'h10, 8'h20, 8'd1);
        run_job(8'hFF, 8'h01, 8'd1);

        // COUNT = 0: immediate result, no adder activity.
        wb_wr(OPND, 32'h0000_775A, 4'b0011);
        wb_wr(CTRL, 32'h0000_0003, 4'b0011);
        rd_chk("zero_status", STATUS, 32'h2);
        rd_chk("zero_result", RESULT, 32'h0000_005A);
        chk("zero_add_a", {24'd0, add_a}, {24'd0, exp_add_a});
        wb_wr(STATUS, 32'h2, 4'b0001);

        run_job(8'hFF, 8'hFF, 8'd255);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom_range(1, 12));
            run_job(ra, rb, rc);
        end

        // Writes and START while busy.
        wb_wr(OPND, 32'h0000_0703, 4'b0011);
        wb_wr(CTRL, 32'h0000_0A03, 4'b0011);
        rd_chk("busy", STATUS, 32'h1);
        wb_wr(OPND, 32'h0000_5555, 4'b0011);
        wb_wr(CTRL, 32'h0000_0301, 4'b0011);
        wait_irq(200, n);
        rd_chk("busy_result", RESULT, 32'd3 + 32'd10 * 32'd7);
        rd_chk("busy_status", STATUS, 32'h6);
        rd_chk("busy_opnd", OPND, 32'h0000_0703);
        rd_chk("busy_ctrl", CTRL, 32'h0000_0A02);
        wb_wr(STATUS, 32'h6, 4'b0001);
        rd_chk("busy_clr", STATUS, 32'h0);

        // Reset mid-job.
        wb_wr(OPND, 32'h0000_0911, 4'b0011);
        wb_wr(CTRL, 32'h0000_0A03, 4'b0011);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out", {ack, irq, add_a, add_b}, 32'd0);
        chk("rst_async_dat", rdat_o, 32'd0);
        #14 rst = 1'b0;
        rd_chk("mrst_opnd", OPND, 32'h0);
        rd_chk("mrst_ctrl", CTRL, 32'h0);
        rd_chk("mrst_status", STATUS, 32'h0);
        rd_chk("mrst_result", RESULT, 32'h0);
        chk("mrst_irq", {31'd0, irq}, 32'd0);
        run_job(8'h21, 8'h05, 8'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
